// File: rtl/lc_packet_arbiter.sv
// Packet arbiter: main and prefetch FIFOs feed one registered output, with a starvation guard for prefetch.
// Optional macro LC_ARB_DROP_CNT_EN adds a saturating 8-bit drop_count output.
module lc_packet_arbiter #(
    parameter int datawidth            = 16,
    parameter int address_vector_width = 8,
    parameter int packet_width         = 2*datawidth + address_vector_width,
    parameter int FIFO_DEPTH           = 4,
    parameter int STARVE_LIMIT         = 3
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic [packet_width-1:0] packet_in,
    input  logic                    packet_in_valid,
    input  logic [packet_width-1:0] prefetch_packet_in,
    input  logic                    prefetch_packet_in_valid,
    output logic [packet_width-1:0] out_packet,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_is_prefetch,
    output logic                    main_full,
    output logic                    pf_full,
`ifdef LC_ARB_DROP_CNT_EN
    output logic [7:0]              drop_count,
`endif
    output logic                    overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    // state    | meaning
    // MAIN_PRI | main queue wins whenever non-empty
    // PF_TURN  | prefetch has waited STARVE_LIMIT main grants; next load takes it
    typedef enum logic {MAIN_PRI, PF_TURN} arb_state_t;

    arb_state_t state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;

    logic [packet_width-1:0] main_mem_q [FIFO_DEPTH];
    logic [packet_width-1:0] main_mem_d [FIFO_DEPTH];
    logic [packet_width-1:0] pf_mem_q   [FIFO_DEPTH];
    logic [packet_width-1:0] pf_mem_d   [FIFO_DEPTH];
    logic [AW-1:0] main_wptr_q, main_wptr_d, main_rptr_q, main_rptr_d;
    logic [AW-1:0] pf_wptr_q, pf_wptr_d, pf_rptr_q, pf_rptr_d;
    logic [CW-1:0] main_cnt_q, main_cnt_d, pf_cnt_q, pf_cnt_d;

    logic [packet_width-1:0] out_packet_q, out_packet_d;
    logic out_valid_q, out_valid_d;
    logic out_is_prefetch_q, out_is_prefetch_d;
    logic overflow_q, overflow_d;

    logic main_empty, pf_empty, main_full_w, pf_full_w;
    logic main_in_ok, pf_in_ok, main_push, pf_push, main_drop, pf_drop;
    logic load, grant_pf, grant_main;

    always_comb begin
        main_empty  = (main_cnt_q == '0);
        pf_empty    = (pf_cnt_q == '0);
        main_full_w = (main_cnt_q == CW'(FIFO_DEPTH));
        pf_full_w   = (pf_cnt_q == CW'(FIFO_DEPTH));

        // dest == 0 is not a packet at all: neither queued nor counted as a drop
        main_in_ok = packet_in_valid && (packet_in[packet_width-1 -: address_vector_width] != '0);
        pf_in_ok   = prefetch_packet_in_valid &&
                     (prefetch_packet_in[packet_width-1 -: address_vector_width] != '0);
        main_push  = main_in_ok && !main_full_w;
        pf_push    = pf_in_ok && !pf_full_w;
        main_drop  = main_in_ok && main_full_w;
        pf_drop    = pf_in_ok && pf_full_w;

        load       = (!out_valid_q || out_ready) && (!main_empty || !pf_empty);
        grant_pf   = load && !pf_empty && ((state_q == PF_TURN) || main_empty);
        grant_main = load && !grant_pf;
    end

    always_comb begin
        main_mem_d  = main_mem_q;
        pf_mem_d    = pf_mem_q;
        main_wptr_d = main_wptr_q;
        main_rptr_d = main_rptr_q;
        pf_wptr_d   = pf_wptr_q;
        pf_rptr_d   = pf_rptr_q;
        main_cnt_d  = main_cnt_q + CW'(main_push) - CW'(grant_main);
        pf_cnt_d    = pf_cnt_q + CW'(pf_push) - CW'(grant_pf);

        if (main_push) begin
            main_mem_d[main_wptr_q] = packet_in;
            main_wptr_d             = main_wptr_q + AW'(1);
        end
        if (pf_push) begin
            pf_mem_d[pf_wptr_q] = prefetch_packet_in;
            pf_wptr_d           = pf_wptr_q + AW'(1);
        end
        if (grant_main) main_rptr_d = main_rptr_q + AW'(1);
        if (grant_pf)   pf_rptr_d   = pf_rptr_q + AW'(1);
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        if (pf_empty) begin
            state_d  = MAIN_PRI;
            starve_d = '0;
        end else if (grant_pf) begin
            state_d  = MAIN_PRI;
            starve_d = '0;
        end else if (grant_main) begin
            if (starve_q >= SW'(STARVE_LIMIT - 1)) begin
                state_d  = PF_TURN;
                starve_d = SW'(STARVE_LIMIT);
            end else begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    always_comb begin
        out_packet_d      = out_packet_q;
        out_valid_d       = out_valid_q;
        out_is_prefetch_d = out_is_prefetch_q;
        overflow_d        = overflow_q | main_drop | pf_drop;
        if (load) begin
            out_packet_d      = grant_pf ? pf_mem_q[pf_rptr_q] : main_mem_q[main_rptr_q];
            out_is_prefetch_d = grant_pf;
            out_valid_d       = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q           <= MAIN_PRI;
            starve_q          <= '0;
            main_mem_q        <= '{default: '0};
            pf_mem_q          <= '{default: '0};
            main_wptr_q       <= '0;
            main_rptr_q       <= '0;
            pf_wptr_q         <= '0;
            pf_rptr_q         <= '0;
            main_cnt_q        <= '0;
            pf_cnt_q          <= '0;
            out_packet_q      <= '0;
            out_valid_q       <= 1'b0;
            out_is_prefetch_q <= 1'b0;
            overflow_q        <= 1'b0;
        end else begin
            state_q           <= state_d;
            starve_q          <= starve_d;
            main_mem_q        <= main_mem_d;
            pf_mem_q          <= pf_mem_d;
            main_wptr_q       <= main_wptr_d;
            main_rptr_q       <= main_rptr_d;
            pf_wptr_q         <= pf_wptr_d;
            pf_rptr_q         <= pf_rptr_d;
            main_cnt_q        <= main_cnt_d;
            pf_cnt_q          <= pf_cnt_d;
            out_packet_q      <= out_packet_d;
            out_valid_q       <= out_valid_d;
            out_is_prefetch_q <= out_is_prefetch_d;
            overflow_q        <= overflow_d;
        end
    end

`ifdef LC_ARB_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic [8:0] drop_sum;

    always_comb begin
        drop_sum   = {1'b0, drop_cnt_q} + 9'(main_drop) + 9'(pf_drop);
        drop_cnt_d = (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) drop_cnt_q <= '0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign drop_count = drop_cnt_q;
`endif

    assign out_packet      = out_packet_q;
    assign out_valid       = out_valid_q;
    assign out_is_prefetch = out_is_prefetch_q;
    assign main_full       = main_full_w;
    assign pf_full         = pf_full_w;
    assign overflow        = overflow_q;

endmodule

// File: doc/lc_packet_arbiter.md
LC_PACKET_ARBITER -- requirements
Module: lc_packet_arbiter

Interface
REQ-001 SHALL have parameter datawidth, default 16, sample half-width; packet carries 2*datawidth data bits.
REQ-002 SHALL have parameter address_vector_width, default 8, destination vector width.
REQ-003 SHALL have parameter packet_width, default 2*datawidth+address_vector_width (40); layout {dest[39:32], data[31:0]}.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, power of two >= 2, entries per input queue.
REQ-005 SHALL have parameter STARVE_LIMIT, default 3, consecutive main grants tolerated while prefetch waits.
REQ-006 SHALL have one clock and an asynchronous active-high reset: CLK and reset.
REQ-007 CLK  input  1  rising-edge clock.
REQ-008 reset  input  1  asynchronous, active-high.
REQ-009 packet_in  input  packet_width  main packet from local controller.
REQ-010 packet_in_valid  input  1  packet_in valid this cycle.
REQ-011 prefetch_packet_in  input  packet_width  prefetch packet from local controller.
REQ-012 prefetch_packet_in_valid  input  1  prefetch_packet_in valid this cycle.
REQ-013 out_packet  output  packet_width  registered packet to NoC router.
REQ-014 out_valid  output  1  out_packet holds a packet.
REQ-015 out_ready  input  1  router accepts out_packet this cycle.
REQ-016 out_is_prefetch  output  1  out_packet came from the prefetch queue.
REQ-017 main_full, pf_full  output  1 each  queue occupancy == FIFO_DEPTH.
REQ-018 overflow  output  1  sticky: a packet was dropped on a full queue.

Function
REQ-019 Input valid with dest == 0 SHALL be discarded, never queued, never counted as overflow.
REQ-020 Input valid with dest != 0 SHALL be written to its queue at the same edge if the queue is not full before that edge; no bypass of a full queue by a same-cycle pop.
REQ-021 Valid input on a full queue SHALL be dropped and SHALL set overflow at that edge.
REQ-022 Output register SHALL load when (!out_valid || out_ready) and either queue is non-empty; otherwise it holds value and out_valid.
REQ-023 out_valid SHALL clear at an edge with out_ready=1 and no queued packet.
REQ-024 Minimum latency: packet written at edge N appears with out_valid=1 after edge N+1.
REQ-025 Arbiter states: MAIN_PRI (default) and PF_TURN.
REQ-026 In MAIN_PRI, main queue SHALL win when non-empty; prefetch SHALL win only when main is empty.
REQ-027 starve_cnt SHALL increment on each main grant while prefetch is non-empty, and clear on any prefetch grant or when prefetch is empty.
REQ-028 When starve_cnt reaches STARVE_LIMIT, state SHALL go to PF_TURN; the next load SHALL take prefetch, then return to MAIN_PRI with starve_cnt=0.
REQ-029 Queues SHALL be FIFO order; read/write pointers SHALL wrap modulo FIFO_DEPTH; push and pop on the same queue in one edge SHALL keep occupancy unchanged.
REQ-030 out_is_prefetch SHALL be updated with out_packet on every load.

Reset
REQ-031 reset=1 SHALL asynchronously clear both queues, pointers, out_valid, out_is_prefetch, overflow, starve_cnt, state=MAIN_PRI, out_packet=0.
REQ-032 Reset mid-transfer SHALL discard all held packets; the first post-reset edge SHALL accept inputs normally.

Configuration
REQ-033 Macro LC_ARB_DROP_CNT_EN SHALL add output drop_count (8 bits), incremented per dropped packet (both queues, one increment per queue per edge, +2 if both drop), saturating at 255, cleared by reset.
REQ-034 Without LC_ARB_DROP_CNT_EN, port drop_count and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-035 Single main packet 0x08_0000FFFF, out_ready=1 -> out_valid after 2 edges, out_packet=0x08_0000FFFF, out_is_prefetch=0.
REQ-036 out_ready=0, 5 main packets 0x08_00000001..05 -> first 4 queued plus 1 in output register? No: first loads output, next 4 fill queue, main_full=1; a 6th is dropped, overflow=1, drop_count=1 with macro.
REQ-037 Continuous main traffic plus 1 prefetch 0x6F_00000050, out_ready=1 -> prefetch emitted after exactly 3 main packets (STARVE_LIMIT=3).
REQ-038 Packets with dest 0x00 on both inputs -> nothing queued, out_valid stays 0, overflow stays 0.
REQ-039 reset asserted while out_valid=1 and queues at 2 entries -> all outputs 0 immediately, no stale packet after release.
REQ-040 Push and pop simultaneously on a full prefetch queue, out_ready=1 -> incoming packet dropped, overflow=1, occupancy becomes FIFO_DEPTH-1.
